// File: rtl/serial_addsub_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_addsub_if
//  Brief    : Operand/result handshake bundle for the bit-serial add/subtract unit
//  Revision : 1.0
// ============================================================================
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid,
        output op,
        output a_in,
        output b_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  cout,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  op,
        input  a_in,
        input  b_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output cout,
        output ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : serial_addsub
//  Brief    : Bit-serial (LSB first) adder/subtractor with valid/ready handshake
//  Revision : 1.0
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    serial_addsub_if.slave    bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;

    logic             w_x;
    logic             w_y;
    logic             w_sum;
    logic             w_carry_out;
    logic             w_ovf;
    logic             w_last;
    logic             w_accept;

    // ------------------------------------------------------------------------
    // One-bit arithmetic cell; the same XOR sum serves both add and subtract
    // ------------------------------------------------------------------------
    always_comb begin
        w_x         = r_a[0];
        w_y         = r_b[0];
        w_sum       = w_x ^ w_y ^ r_carry;
        w_carry_out = 1'b0;
        w_ovf       = 1'b0;
        if (r_op) begin
            w_carry_out = (~w_x & w_y) | (~(w_x ^ w_y) & r_carry);
            // Signed overflow on subtract: operand signs differ and result sign flips
            w_ovf       = (w_x ^ w_y) & (w_sum ^ w_x);
        end else begin
            w_carry_out = (w_x & w_y) | (w_y & r_carry) | (w_x & r_carry);
            w_ovf       = r_carry ^ w_carry_out;
        end
    end

    assign w_last   = (r_cnt == C_LAST);
    assign w_accept = (r_state == S_IDLE) && bus.in_valid;

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a_in;
            r_b     <= bus.b_in;
            r_op    <= bus.op;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_carry  <= w_carry_out;
            // New bit enters at the MSB end so bit i lands at position i after WIDTH shifts
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            if (w_last) begin
                r_cout <= w_carry_out;
                r_ovf  <= w_ovf;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_addsub
//  Brief    : Scoreboard bench for serial_addsub (WIDTH = 8)
//  Revision : 1.0
// ============================================================================
module tb_serial_addsub;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] t;
        if (!o) begin
            t   = {1'b0, a} + {1'b0, b};
            e.c = t[W];
            e.v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        end else begin
            t   = {1'b0, a} - {1'b0, b};
            e.c = (a < b);
            e.v = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
        end
        e.res = t[W-1:0];
        return e;
    endfunction

    // Accept one operand set, scramble inputs while busy, return cycles until out_valid
    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic rdy, output int lat);
        int guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        bus.op        = o;
        bus.a_in      = a;
        bus.b_in      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = rdy;
        sb.push_back(model(o, a, b));
        tick();
        bus.op       = ~o;
        bus.a_in     = W'($urandom);
        bus.b_in     = W'($urandom);
        bus.in_valid = 1'($urandom_range(0, 1));
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.cout, bus.ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b res=%h c=%b v=%b required rdy=1 vld=0 res=00 c=0 v=0",
                     bus.in_ready, bus.out_valid, bus.result, bus.cout, bus.ovf);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[5] = '{8'hFF, 8'h05, 8'h80, 8'h7F, 8'h00};
        logic [W-1:0] vb[5] = '{8'h01, 8'h07, 8'h01, 8'h01, 8'h00};
        logic         vo[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_t         e;
        int           lat;
        for (int i = 0; i < 5; i++) begin
            run_op(vo[i], va[i], vb[i], 1'b1, lat);
            n_checks++;
            if (lat !== W) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: %0d edges after accept, required %0d", i, lat, W);
            end
            e = sb.pop_front();
            n_checks++;
            if ({bus.result, bus.cout, bus.ovf} !== {e.res, e.c, e.v}) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: res=%h c=%b v=%b required res=%h c=%b v=%b",
                         i, bus.result, bus.cout, bus.ovf, e.res, e.c, e.v);
            end
            consume();
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int   lat;
        run_op(1'b0, 8'h3C, 8'hC5, 1'b0, lat);
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = (k % 2 == 0);
            bus.a_in     = W'($urandom);
            bus.b_in     = W'($urandom);
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.result, bus.cout, bus.ovf} !== {1'b1, 1'b0, e.res, e.c, e.v}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: vld=%b rdy=%b res=%h c=%b v=%b required vld=1 rdy=0 res=%h c=%b v=%b",
                         k, bus.out_valid, bus.in_ready, bus.result, bus.cout, bus.ovf, e.res, e.c, e.v);
            end
            tick();
        end
        consume();
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.cout, bus.ovf} !== {1'b1, 1'b0, e.res, e.c, e.v}) begin
            n_fail++;
            $display("FAIL stall_release: rdy=%b vld=%b res=%h required rdy=1 vld=0 res=%h",
                     bus.in_ready, bus.out_valid, bus.result, e.res);
        end
    endtask

    task automatic test_mid_run_reset();
        exp_t e;
        int   lat;
        bus.op       = 1'b0;
        bus.a_in     = 8'hAA;
        bus.b_in     = 8'h57;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL run_flags: rdy=%b vld=%b required rdy=0 vld=0", bus.in_ready, bus.out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.cout, bus.ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrun_reset: rdy=%b vld=%b res=%h c=%b v=%b required rdy=1 vld=0 res=00 c=0 v=0",
                     bus.in_ready, bus.out_valid, bus.result, bus.cout, bus.ovf);
        end
        run_op(1'b0, 8'h12, 8'h34, 1'b1, lat);
        e = sb.pop_front();
        n_checks++;
        if ({lat, bus.result, bus.cout, bus.ovf} !== {W, e.res, e.c, e.v}) begin
            n_fail++;
            $display("FAIL post_reset_op: lat=%0d res=%h c=%b v=%b required lat=%0d res=%h c=%b v=%b",
                     lat, bus.result, bus.cout, bus.ovf, W, e.res, e.c, e.v);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] corner[4] = '{8'h00, 8'hFF, 8'h7F, 8'h80};
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         o;
        logic         rdy;
        exp_t         e;
        int           lat;
        for (int i = 0; i < 1000; i++) begin
            o   = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rdy = 1'($urandom_range(0, 1));
            run_op(o, a, b, rdy, lat);
            n_checks++;
            if (lat !== W) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: %0d required %0d", i, lat, W);
            end
            e = sb.pop_front();
            n_checks++;
            if ({bus.result, bus.cout, bus.ovf} !== {e.res, e.c, e.v}) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: op=%b a=%h b=%h res=%h c=%b v=%b required res=%h c=%b v=%b",
                         i, o, a, b, bus.result, bus.cout, bus.ovf, e.res, e.c, e.v);
            end
            if (!rdy) repeat ($urandom_range(0, 3)) tick();
            consume();
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_idle[%0d]: rdy=%b required 1", i, bus.in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_mid_run_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
